pipeline_muldiv: RTL

- Parametrised multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU stage, which issues mult/multu/div/divu/mthi/mtlo with resolved operands and reads HI/LO for mfhi/mflo.
- Multiplies are pipelined with fixed latency; divides are iterative, radix selectable.
- A stall output holds the issuing stage while a result is pending.

---
 rtl/pipeline_muldiv_if.sv | 27 ++
 rtl/pipeline_muldiv.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_muldiv_if.sv
// Issue/result bundle between the ALU stage and the multiply/divide unit.
// master = issuing stage, slave = pipeline_muldiv.
interface pipeline_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
    logic             flush;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             illegal;

    modport master (
        output op_valid, op, a, b, mf_req, flush,
        input  stall, busy, hi_out, lo_out, illegal
    );

    modport slave (
        input  op_valid, op, a, b, mf_req, flush,
        output stall, busy, hi_out, lo_out, illegal
    );
endinterface

// File: rtl/pipeline_muldiv.sv
// Multiply/divide unit with architectural HI/LO: fixed-latency multiply, iterative restoring divide.
// Define MULDIV_MADD_EN to enable madd/maddu/msub/msubu (otherwise those codes are illegal).
module pipeline_muldiv #(
    parameter int WIDTH          = 32,
    parameter int MUL_LATENCY    = 2,
    parameter int DIV_RADIX_BITS = 1
) (
    input logic              clk,
    input logic              rst,
    pipeline_muldiv_if.slave bus
);
    localparam int DIV_ITERS = WIDTH / DIV_RADIX_BITS;
    localparam int CNT_MAX   = (DIV_ITERS > MUL_LATENCY) ? DIV_ITERS : MUL_LATENCY;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int PW        = 2 * WIDTH + 2;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DIVFIX} state_t;

    state_t                  state;
    logic                    busy_q;
    logic                    illegal_q;
    logic [WIDTH-1:0]        hi_q, lo_q;
    logic [CW-1:0]           cnt;
    logic signed [WIDTH:0]   ma, mb;
    logic                    acc_en, acc_sub;
    logic [WIDTH:0]          rem_q;
    logic [WIDTH-1:0]        quo_q, dvs_q;
    logic                    q_neg, r_neg, dz;

    logic is_mul, mul_sgn, is_acc, is_sub, is_div, div_sgn, is_mthi, is_mtlo, legal;

    always_comb begin
        is_mul  = 1'b0;
        mul_sgn = 1'b0;
        is_acc  = 1'b0;
        is_sub  = 1'b0;
        is_div  = 1'b0;
        div_sgn = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        legal   = 1'b1;
        case (bus.op)
            OP_MULT:  begin is_mul = 1'b1; mul_sgn = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; div_sgn = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; mul_sgn = 1'b1; is_acc = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; mul_sgn = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default:  legal = 1'b0;
        endcase
    end

    // Divide operands are reduced to magnitudes; signs are reapplied in DIVFIX.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = div_sgn & bus.a[WIDTH-1];
    assign b_neg = div_sgn & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // Operands carry an extra sign bit so one signed multiplier serves both signednesses.
    logic signed [PW-1:0]  prod;
    logic [2*WIDTH-1:0]    hilo, mul_res;
    assign prod    = PW'(ma) * PW'(mb);
    assign hilo    = {hi_q, lo_q};
    assign mul_res = !acc_en ? prod[2*WIDTH-1:0] :
                     acc_sub ? hilo - prod[2*WIDTH-1:0] : hilo + prod[2*WIDTH-1:0];

    logic [WIDTH:0]   r_nx;
    logic [WIDTH-1:0] q_nx;
    always_comb begin
        r_nx = rem_q;
        q_nx = quo_q;
        for (int unsigned i = 0; i < DIV_RADIX_BITS; i++) begin
            r_nx = {r_nx[WIDTH-1:0], q_nx[WIDTH-1]};
            q_nx = {q_nx[WIDTH-2:0], 1'b0};
            if (r_nx >= {1'b0, dvs_q}) begin
                r_nx    = r_nx - {1'b0, dvs_q};
                q_nx[0] = 1'b1;
            end
        end
    end

    logic [WIDTH-1:0] div_hi, div_lo;
    assign div_hi = dz ? quo_q : (r_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]);
    assign div_lo = dz ? '1    : (q_neg ? -quo_q : quo_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt       <= '0;
            ma        <= '0;
            mb        <= '0;
            acc_en    <= 1'b0;
            acc_sub   <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz        <= 1'b0;
        end else if (bus.flush) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                IDLE: if (bus.op_valid) begin
                    if (is_mthi) hi_q <= bus.a;
                    if (is_mtlo) lo_q <= bus.a;
                    if (is_mul) begin
                        ma      <= mul_sgn ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
                        mb      <= mul_sgn ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
                        acc_en  <= is_acc;
                        acc_sub <= is_sub;
                        cnt     <= CW'(MUL_LATENCY);
                        busy_q  <= 1'b1;
                        state   <= MUL;
                    end
                    if (is_div) begin
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        rem_q  <= '0;
                        dvs_q  <= b_mag;
                        cnt    <= CW'(DIV_ITERS);
                        busy_q <= 1'b1;
                        if (bus.b == '0) begin
                            dz    <= 1'b1;
                            quo_q <= bus.a;
                            state <= DIVFIX;
                        end else begin
                            dz    <= 1'b0;
                            quo_q <= a_mag;
                            state <= DIV;
                        end
                    end
                    if (!legal) illegal_q <= 1'b1;
                end
                MUL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        {hi_q, lo_q} <= mul_res;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                DIV: begin
                    rem_q <= r_nx;
                    quo_q <= q_nx;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= DIVFIX;
                end
                DIVFIX: begin
                    hi_q   <= div_hi;
                    lo_q   <= div_lo;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall   = busy_q && (bus.op_valid || bus.mf_req);
    assign bus.busy    = busy_q;
    assign bus.hi_out  = hi_q;
    assign bus.lo_out  = lo_q;
    assign bus.illegal = illegal_q;
endmodule
